fp_mul_arbiter: RTL and testbench

Shares one FP32 multiplier datapath (sign XOR, biased-exponent add, 24x24 mantissa product, 1-bit normalise, round-half-up) among NUM_REQ requesters.
- Round-robin arbitration at issue.
- Multiplier wrapped in a MUL_LATENCY-deep register pipeline.
- Each result returned on a single output channel, tagged with the requester index.
- Sits between the vector/accumulator front ends and the multiplier datapath.

---
 rtl/fp_mul_arbiter_if.sv | 26 ++
 rtl/fp_mul_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// Request/result bundle between the front ends and the shared FP32 multiplier.
// master: front-end / consumer side. slave: the arbiter itself.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [31:0]           out_product;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_tag, out_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_tag, out_product, busy
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter in front of one shared FP32 multiplier.
// Stage 1 latches the granted operands, stage 2 holds the product, the
// remaining stages are pure delay; the whole pipe freezes while the output
// is stalled. Results carry the requester index as a tag.
// Optional macro FPMUL_ARB_STATS_EN adds saturating issue/stall counters.
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int TAG_W       = 2
) (
  input  logic clk,
  input  logic rst,
  fp_mul_arbiter_if.slave bus
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] stat_issue,
  output logic [15:0]           stat_stall
`endif
);

  // (base + off) mod NUM_REQ, with off < NUM_REQ so one subtraction suffices
  function automatic logic [TAG_W-1:0] rr_next(input logic [TAG_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return TAG_W'(sum);
  endfunction

  logic                 s1_valid_reg;
  logic [31:0]          s1_a_reg;
  logic [31:0]          s1_b_reg;
  logic [TAG_W-1:0]     s1_tag_reg;
  logic [TAG_W-1:0]     ptr_reg;

  logic                 stg_valid_reg [2:MUL_LATENCY];
  logic [TAG_W-1:0]     stg_tag_reg   [2:MUL_LATENCY];
  logic [31:0]          stg_prod_reg  [2:MUL_LATENCY];
  logic                 feed_valid    [2:MUL_LATENCY];
  logic [TAG_W-1:0]     feed_tag      [2:MUL_LATENCY];
  logic [31:0]          feed_prod     [2:MUL_LATENCY];

  logic                 stall;
  logic                 grant_found;
  logic [TAG_W-1:0]     grant_idx;
  logic                 fire;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy_any;

  logic [47:0]          mul_p;
  logic [22:0]          mul_mant;
  logic [7:0]           mul_exp;
  logic [31:0]          mul_result;

  assign stall = stg_valid_reg[MUL_LATENCY] & ~bus.out_ready;

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_found && bus.req_valid[rr_next(ptr_reg, off)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_next(ptr_reg, off);
      end
    end
  end

  assign fire = grant_found & ~stall & ~rst;

  // One-hot ready towards the winning requester only.
  always_comb begin
    grant = '0;
    if (fire) grant[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant;

  // Latch the granted operands and advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_tag_reg   <= '0;
      ptr_reg      <= '0;
    end else if (!stall) begin
      s1_valid_reg <= fire;
      if (fire) begin
        s1_a_reg   <= bus.req_a[32*grant_idx +: 32];
        s1_b_reg   <= bus.req_b[32*grant_idx +: 32];
        s1_tag_reg <= grant_idx;
        ptr_reg    <= rr_next(grant_idx, 1);
      end
    end
  end

  // Multiply: implicit ones always present, 1-bit normalise, round half up.
  // Mantissa carry-out from rounding is dropped; exponent bias -127 is +129 mod 256.
  always_comb begin
    mul_p = 48'({1'b1, s1_a_reg[22:0]}) * 48'({1'b1, s1_b_reg[22:0]});
    if (mul_p[47]) mul_mant = mul_p[46:24] + 23'(mul_p[23]);
    else           mul_mant = mul_p[45:23] + 23'(mul_p[22]);
    mul_exp    = s1_a_reg[30:23] + s1_b_reg[30:23] + 8'd129 + 8'(mul_p[47]);
    mul_result = {s1_a_reg[31] ^ s1_b_reg[31], mul_exp, mul_mant};
  end

  genvar gi;
  generate
    for (gi = 2; gi <= MUL_LATENCY; gi++) begin : g_stage
      if (gi == 2) begin : g_head
        assign feed_valid[gi] = s1_valid_reg;
        assign feed_tag[gi]   = s1_tag_reg;
        assign feed_prod[gi]  = mul_result;
      end else begin : g_tail
        assign feed_valid[gi] = stg_valid_reg[gi-1];
        assign feed_tag[gi]   = stg_tag_reg[gi-1];
        assign feed_prod[gi]  = stg_prod_reg[gi-1];
      end

      // Shift one stage forward unless the output is stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          stg_valid_reg[gi] <= 1'b0;
          stg_tag_reg[gi]   <= '0;
          stg_prod_reg[gi]  <= '0;
        end else if (!stall) begin
          stg_valid_reg[gi] <= feed_valid[gi];
          stg_tag_reg[gi]   <= feed_tag[gi];
          stg_prod_reg[gi]  <= feed_prod[gi];
        end
      end
    end
  endgenerate

  // Busy whenever any stage carries a live op.
  always_comb begin
    busy_any = s1_valid_reg;
    for (int s = 2; s <= MUL_LATENCY; s++) busy_any = busy_any | stg_valid_reg[s];
  end

  assign bus.out_valid   = stg_valid_reg[MUL_LATENCY];
  assign bus.out_tag     = stg_tag_reg[MUL_LATENCY];
  assign bus.out_product = stg_prod_reg[MUL_LATENCY];
  assign bus.busy        = busy_any;

`ifdef FPMUL_ARB_STATS_EN
  logic [15:0] issue_cnt_reg [NUM_REQ];
  logic [15:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      // Count handshakes of this requester, saturating.
      always_ff @(posedge clk) begin
        if (rst) issue_cnt_reg[gi] <= '0;
        else if (grant[gi] && issue_cnt_reg[gi] != 16'hFFFF) issue_cnt_reg[gi] <= issue_cnt_reg[gi] + 16'd1;
      end
      assign stat_issue[16*gi +: 16] = issue_cnt_reg[gi];
    end
  endgenerate

  // Count output stall cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_reg <= '0;
    else if (stall && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stat_stall = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of in-flight ops.
module tb_fp_mul_arbiter;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

`ifdef FPMUL_ARB_STATS_EN
  logic [16*N-1:0] stat_issue;
  logic [15:0]     stat_stall;
`endif

  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FPMUL_ARB_STATS_EN
    ,
    .stat_issue(stat_issue),
    .stat_stall(stat_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference FP32 multiply from the arithmetic rules, using wide integers.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, p, top, sh, m;
    int e;
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    p   = ma * mb;
    top = (p >> 47) & 1;
    sh  = (top != 0) ? 24 : 23;
    m   = ((p >> sh) + ((p >> (sh - 1)) & 1)) & 64'h7FFFFF;
    e   = (int'(a[30:23]) + int'(b[30:23]) - 127 + int'(top)) & 255;
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  // Model: every live op with its pipeline position (1 = just issued).
  typedef struct {
    int          tag;
    logic [31:0] prod;
    int          age;
  } op_t;

  op_t pipe_q[$];
  int  rr_p = 0;
  int  issue_m [N];
  int  stall_m = 0;

  logic         exp_valid;
  logic         exp_stall;
  logic [N-1:0] exp_ready;
  int           g;

  // Compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    exp_valid = (pipe_q.size() > 0) && (pipe_q[0].age == L);
    exp_stall = exp_valid && !bus.out_ready;
    exp_ready = '0;
    g = -1;
    if (!rst && !exp_stall)
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.req_valid[(rr_p + k) % N]) g = (rr_p + k) % N;
    if (g >= 0) exp_ready[g] = 1'b1;

    check("out_valid", bus.out_valid, exp_valid);
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", bus.busy, pipe_q.size() > 0);
    if (exp_valid) begin
      check("out_tag", bus.out_tag, pipe_q[0].tag);
      check("out_product", bus.out_product, pipe_q[0].prod);
      if (bus.out_ready)
        $display("result tag=%0d product=0x%08h t=%0t", bus.out_tag, bus.out_product, $time);
    end
`ifdef FPMUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_issue", stat_issue[16*i +: 16], issue_m[i]);
    check("stat_stall", stat_stall, stall_m);
`endif

    if (rst) begin
      pipe_q.delete();
      rr_p = 0;
      for (int i = 0; i < N; i++) issue_m[i] = 0;
      stall_m = 0;
    end else if (exp_stall) begin
      if (stall_m < 16'hFFFF) stall_m++;
    end else begin
      if (exp_valid) void'(pipe_q.pop_front());
      for (int j = 0; j < pipe_q.size(); j++) pipe_q[j].age = pipe_q[j].age + 1;
      if (g >= 0) begin
        pipe_q.push_back('{tag: g,
                           prod: ref_mul(bus.req_a[32*g +: 32], bus.req_b[32*g +: 32]),
                           age: 1});
        rr_p = (g + 1) % N;
        if (issue_m[g] < 16'hFFFF) issue_m[g]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) set_req(i, $urandom(), $urandom());
  endtask

  logic [31:0] held_prod;
  logic [TW-1:0] held_tag;

  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b1;

    // Pin the reference model itself.
    check("ref_pin_a", ref_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
    check("ref_pin_b", ref_mul(32'hC0000000, 32'h40400000), 32'hC0C00000);

    // Reset with requests pending: nothing may be granted.
    tick();
    @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_product", bus.out_product, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    tick();

    // Single op from requester 0, latency 2 edges after the handshake.
    set_req(0, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("single_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_early_k0", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("single_early_k1", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("single_valid", bus.out_valid, 1);
    check("single_tag", bus.out_tag, 0);
    check("single_product", bus.out_product, 32'h40400000);
    repeat (3) tick();

    // Sign and normalise from requester 2 (pointer now at 1).
    set_req(2, 32'hC0000000, 32'h40400000);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("sign_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    check("sign_valid", bus.out_valid, 1);
    check("sign_tag", bus.out_tag, 2);
    check("sign_product", bus.out_product, 32'hC0C00000);
    repeat (3) tick();

    // Round robin from a fresh reset with every requester asking.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      rand_operands();
      @(negedge clk);
      check("rr_grant", bus.req_ready, 4'b0001 << (r % 4));
      tick();
    end

    // Backpressure while the pipe is full.
    @(negedge clk);
    held_prod = bus.out_product;
    held_tag  = bus.out_tag;
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_ready", bus.req_ready, 0);
      check("bp_hold_product", bus.out_product, held_prod);
      check("bp_hold_tag", bus.out_tag, held_tag);
      tick();
      rand_operands();
    end
    bus.out_ready = 1'b1;
    repeat (6) tick();

    // Reset with ops in flight: everything discarded, pointer back to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = '1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_grant", bus.req_ready, 4'b0001);
    tick();

    // Random traffic with backpressure and occasional resets.
    for (int c = 0; c < 700; c++) begin
      rand_operands();
      bus.req_valid = N'($urandom());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("drain_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
